// File: rtl/m_ext_reservation_station.sv
// Age-ordered reservation station for the M-lane: compacting queue with CDB wake-up, oldest-ready select.
// Dispatch is combinational from registered entries; issue is refused whenever the queue is full.
module m_ext_reservation_station #(
  parameter int XLEN                = 64,
  parameter int ROB_INDEX_WIDTH     = 8,
  parameter int DECODED_INSTR_WIDTH = 6,
  parameter int DEPTH               = 4
) (
  input  logic                           clock_i,
  input  logic                           reset_i,
  input  logic                           issue_valid_i,
  output logic                           issue_ready_o,
  input  logic [DECODED_INSTR_WIDTH-1:0] issue_decoded_instruction_i,
  input  logic [ROB_INDEX_WIDTH-1:0]     issue_ROB_index_i,
  input  logic                           issue_1st_ready_i,
  input  logic                           issue_2nd_ready_i,
  input  logic [XLEN-1:0]                issue_1st_value_i,
  input  logic [XLEN-1:0]                issue_2nd_value_i,
  input  logic [ROB_INDEX_WIDTH-1:0]     issue_1st_tag_i,
  input  logic [ROB_INDEX_WIDTH-1:0]     issue_2nd_tag_i,
  input  logic                           cdb_valid_i,
  input  logic [ROB_INDEX_WIDTH-1:0]     cdb_ROB_index_i,
  input  logic [XLEN-1:0]                cdb_value_i,
  output logic                           dispatch_valid_o,
  input  logic                           dispatch_ready_i,
  output logic [XLEN-1:0]                dispatch_1st_reg_o,
  output logic [XLEN-1:0]                dispatch_2nd_reg_o,
  output logic [DECODED_INSTR_WIDTH-1:0] dispatch_decoded_instruction_o,
  output logic [ROB_INDEX_WIDTH-1:0]     dispatch_ROB_index_o,
  input  logic                           flush_i
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic                           vld;
    logic [DECODED_INSTR_WIDTH-1:0] op;
    logic [ROB_INDEX_WIDTH-1:0]     rob;
    logic                           rdy1;
    logic [XLEN-1:0]                val1;
    logic [ROB_INDEX_WIDTH-1:0]     tag1;
    logic                           rdy2;
    logic [XLEN-1:0]                val2;
    logic [ROB_INDEX_WIDTH-1:0]     tag2;
  } entry_t;

  entry_t          r_ent [DEPTH];
  logic [CW-1:0]   r_count;

  entry_t          w_shift [DEPTH];
  entry_t          w_nxt   [DEPTH];
  entry_t          w_new;
  entry_t          w_sel_ent;
  logic            w_sel_found;
  logic [IW-1:0]   w_sel_idx;
  logic            w_fire;
  logic            w_issue_acc;
  logic [CW-1:0]   w_wr_idx;
  logic [CW-1:0]   w_count_nxt;

  assign issue_ready_o = (r_count != FULL);
  assign w_issue_acc   = issue_valid_i & issue_ready_o;
  assign w_fire        = w_sel_found & dispatch_ready_i;

  // Oldest ready entry wins: scan from the top so the lowest index is written last.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (r_ent[i].vld && r_ent[i].rdy1 && r_ent[i].rdy2) begin
        w_sel_found = 1'b1;
        w_sel_idx   = i[IW-1:0];
      end
    end
  end

  always_comb begin
    w_sel_ent = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_sel_found && (i == int'(w_sel_idx))) w_sel_ent = r_ent[i];
    end
  end

  assign dispatch_valid_o               = w_sel_found;
  assign dispatch_1st_reg_o             = w_sel_ent.val1;
  assign dispatch_2nd_reg_o             = w_sel_ent.val2;
  assign dispatch_decoded_instruction_o = w_sel_ent.op;
  assign dispatch_ROB_index_o           = w_sel_ent.rob;

  always_comb begin
    w_new      = '0;
    w_new.vld  = 1'b1;
    w_new.op   = issue_decoded_instruction_i;
    w_new.rob  = issue_ROB_index_i;
    w_new.rdy1 = issue_1st_ready_i;
    w_new.val1 = issue_1st_value_i;
    w_new.tag1 = issue_1st_tag_i;
    w_new.rdy2 = issue_2nd_ready_i;
    w_new.val2 = issue_2nd_value_i;
    w_new.tag2 = issue_2nd_tag_i;
    if (!issue_1st_ready_i && cdb_valid_i && (cdb_ROB_index_i == issue_1st_tag_i)) begin
      w_new.rdy1 = 1'b1;
      w_new.val1 = cdb_value_i;
    end
    if (!issue_2nd_ready_i && cdb_valid_i && (cdb_ROB_index_i == issue_2nd_tag_i)) begin
      w_new.rdy2 = 1'b1;
      w_new.val2 = cdb_value_i;
    end
  end

  assign w_wr_idx    = w_fire ? (r_count - CW'(1)) : r_count;
  assign w_count_nxt = flush_i ? '0 : (r_count + CW'(w_issue_acc) - CW'(w_fire));

  // Compact first, then wake up and write the new op into the shifted image.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) w_shift[i] = r_ent[i];
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (w_fire && (i >= int'(w_sel_idx))) w_shift[i] = r_ent[i+1];
    end
    if (w_fire) w_shift[DEPTH-1] = '0;

    for (int i = 0; i < DEPTH; i++) begin
      w_nxt[i] = w_shift[i];
      if (cdb_valid_i && w_shift[i].vld) begin
        if (!w_shift[i].rdy1 && (w_shift[i].tag1 == cdb_ROB_index_i)) begin
          w_nxt[i].rdy1 = 1'b1;
          w_nxt[i].val1 = cdb_value_i;
        end
        if (!w_shift[i].rdy2 && (w_shift[i].tag2 == cdb_ROB_index_i)) begin
          w_nxt[i].rdy2 = 1'b1;
          w_nxt[i].val2 = cdb_value_i;
        end
      end
      if (w_issue_acc && (i == int'(w_wr_idx))) w_nxt[i] = w_new;
      if (flush_i) w_nxt[i].vld = 1'b0;
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
    end else begin
      r_count <= w_count_nxt;
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= w_nxt[i];
    end
  end

endmodule
